// File: rtl/matrixmult_sequencer_pkg.sv
// Shared constants, state encoding and sizing helpers for the matrix-multiply sequencer.
package matrixmult_pkg;

    localparam int DATA_W = 32;
    localparam int N      = 4;
    localparam int NN     = N * N;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_OUT
    } state_t;

    function automatic int tmo_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/matrixmult_sequencer_if.sv
// Bundle of matrix-write, pixel-in, multiplier and result-out signals of the sequencer.
interface matrixmult_sequencer_if
    import matrixmult_pkg::*;
#(
    parameter int DATA_W = matrixmult_pkg::DATA_W
);

    logic                  mat_we;
    logic [IDX_W-1:0]      mat_addr;
    logic [DATA_W-1:0]     mat_wdata;

    logic                  pix_valid;
    logic                  pix_ready;
    logic [N*DATA_W-1:0]   pix_data;

    logic [DATA_W-1:0]     mm_a;
    logic [DATA_W-1:0]     mm_b;
    logic                  mm_tvalid;
    logic [DATA_W-1:0]     mm_result0;
    logic [DATA_W-1:0]     mm_result1;
    logic [DATA_W-1:0]     mm_result2;
    logic [DATA_W-1:0]     mm_result3;
    logic                  mm_done;

    logic                  out_valid;
    logic                  out_ready;
    logic [N*DATA_W-1:0]   out_data;

    logic                  busy;
    logic                  timeout_err;

    modport slave (
        input  mat_we, mat_addr, mat_wdata,
        input  pix_valid, pix_data,
        output pix_ready,
        output mm_a, mm_b, mm_tvalid,
        input  mm_result0, mm_result1, mm_result2, mm_result3, mm_done,
        output out_valid, out_data,
        input  out_ready,
        output busy, timeout_err
    );

    modport master (
        output mat_we, mat_addr, mat_wdata,
        output pix_valid, pix_data,
        input  pix_ready,
        input  mm_a, mm_b, mm_tvalid,
        output mm_result0, mm_result1, mm_result2, mm_result3, mm_done,
        input  out_valid, out_data,
        output out_ready,
        input  busy, timeout_err
    );

endinterface

// File: rtl/matrixmult_sequencer_regfile.sv
// 16-entry matrix store: synchronous write, combinational read, cleared on reset.
module matrix_regfile
    import matrixmult_pkg::*;
#(
    parameter int DATA_W = matrixmult_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [NN];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NN; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/matrixmult_sequencer.sv
// Streams the 16 (M[r][c], pixel[c]) pairs into the multiplier and returns its four row results.
module matrixmult_sequencer
    import matrixmult_pkg::*;
#(
    parameter int DATA_W       = matrixmult_pkg::DATA_W,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    matrixmult_sequencer_if.slave  bus
);

    localparam int                TMO_W    = tmo_width(DONE_TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_k;
    logic [TMO_W-1:0]    r_tmo;
    logic [N*DATA_W-1:0] r_pix;
    logic [DATA_W-1:0]   r_mm_a;
    logic [DATA_W-1:0]   r_mm_b;
    logic                r_mm_tvalid;
    logic                r_out_valid;
    logic [N*DATA_W-1:0] r_out_data;
    logic                r_timeout_err;

    logic                w_idle;
    logic                w_we;
    logic [IDX_W-1:0]    w_raddr;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   w_a_first;
    logic [DATA_W-1:0]   w_pix_k;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_we    = bus.mat_we && w_idle;
    assign w_raddr = w_idle ? '0 : r_k;

    matrix_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (bus.mat_addr),
        .i_wdata (bus.mat_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Pair 0 is registered on the accepting edge, so a same-cycle write to M[0] is forwarded.
    assign w_a_first = (bus.mat_we && bus.mat_addr == '0) ? bus.mat_wdata : w_rdata;

    always_comb begin
        w_pix_k = r_pix[DATA_W-1:0];
        case (r_k[1:0])
            2'd1:    w_pix_k = r_pix[1*DATA_W +: DATA_W];
            2'd2:    w_pix_k = r_pix[2*DATA_W +: DATA_W];
            2'd3:    w_pix_k = r_pix[3*DATA_W +: DATA_W];
            default: w_pix_k = r_pix[DATA_W-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_k           <= '0;
            r_tmo         <= '0;
            r_pix         <= '0;
            r_mm_a        <= '0;
            r_mm_b        <= '0;
            r_mm_tvalid   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.pix_valid) begin
                        r_pix       <= bus.pix_data;
                        r_mm_a      <= w_a_first;
                        r_mm_b      <= bus.pix_data[DATA_W-1:0];
                        r_mm_tvalid <= 1'b1;
                        r_k         <= IDX_W'(1);
                        r_state     <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    r_mm_a <= w_rdata;
                    r_mm_b <= w_pix_k;
                    if (r_k == IDX_W'(NN - 1)) begin
                        r_tmo   <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_k <= r_k + IDX_W'(1);
                    end
                end
                ST_WAIT: begin
                    r_mm_tvalid <= 1'b0;
                    if (bus.mm_done) begin
                        r_out_data  <= {bus.mm_result3, bus.mm_result2,
                                        bus.mm_result1, bus.mm_result0};
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end else if (r_tmo == TMO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pix_ready   = w_idle;
    assign bus.busy        = !w_idle;
    assign bus.mm_a        = r_mm_a;
    assign bus.mm_b        = r_mm_b;
    assign bus.mm_tvalid   = r_mm_tvalid;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_matrixmult_sequencer.sv
// Directed bench for matrixmult_sequencer; the bench plays the multiplier and downstream sink.
module tb_matrixmult_sequencer;

    localparam int DW  = 32;
    localparam int TMO = 64;

    localparam logic [127:0] PIX1 = {32'h4040A3D7, 32'hC1691EB8, 32'h4141999A, 32'hBF07AE14};
    localparam logic [127:0] PIX2 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    localparam logic [127:0] RES  = {32'h4082161E, 32'h43B80498, 32'h43BBB7CF, 32'hC0E08E56};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matrixmult_sequencer_if #(.DATA_W(DW)) bus();

    matrixmult_sequencer #(
        .DATA_W       (DW),
        .DONE_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ov_seen;

    logic [31:0] m_init [16] = '{
        32'h4124CCCD, 32'h40C80000, 32'h40A9999A, 32'h3C4CCCCD,
        32'h40600000, 32'h40980000, 32'h4111999A, 32'h43164CCD,
        32'hBF07AE14, 32'h4141999A, 32'hC1691EB8, 32'h4040A3D7,
        32'h3C4CCCCD, 32'h40A9999A, 32'h40C80000, 32'h4124CCCD
    };
    logic [31:0] exp_m [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [127:0] pix);
        bus.pix_data  = pix;
        bus.pix_valid = 1'b1;
        chk("accept_ready", bus.pix_ready, 1);
        tick();
        bus.pix_valid = 1'b0;
    endtask

    // Entered just after the accepting edge; leaves just after the edge that drops mm_tvalid.
    task automatic feed_pairs(input logic [127:0] pix);
        logic [127:0] p;
        p = pix;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("tvalid_k%0d", k), bus.mm_tvalid, 1);
            chk($sformatf("mm_a_k%0d", k), bus.mm_a, exp_m[k]);
            chk($sformatf("mm_b_k%0d", k), bus.mm_b, p[(k % 4) * 32 +: 32]);
            tick();
        end
        chk("tvalid_after_feed", bus.mm_tvalid, 0);
        chk("busy_in_wait", bus.busy, 1);
    endtask

    task automatic pulse_done(input logic [127:0] res);
        bus.mm_result0 = res[31:0];
        bus.mm_result1 = res[63:32];
        bus.mm_result2 = res[95:64];
        bus.mm_result3 = res[127:96];
        bus.mm_done    = 1'b1;
        tick();
        bus.mm_done    = 1'b0;
        bus.mm_result0 = '0;
        bus.mm_result1 = '0;
        bus.mm_result2 = '0;
        bus.mm_result3 = '0;
        chk("out_valid_after_done", bus.out_valid, 1);
        chk("out_data", bus.out_data, res);
        chk("pix_ready_in_out", bus.pix_ready, 0);
    endtask

    task automatic deliver(input logic [127:0] res);
        chk("no_early_out_valid", bus.out_valid, 0);
        tick();
        chk("no_early_out_valid2", bus.out_valid, 0);
        pulse_done(res);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("out_valid_cleared", bus.out_valid, 0);
        chk("pix_ready_after_hs", bus.pix_ready, 1);
        chk("busy_after_hs", bus.busy, 0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.mat_we     = 1'b0;
        bus.mat_addr   = '0;
        bus.mat_wdata  = '0;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        bus.mm_result0 = '0;
        bus.mm_result1 = '0;
        bus.mm_result2 = '0;
        bus.mm_result3 = '0;
        bus.mm_done    = 1'b0;
        bus.out_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_pix_ready", bus.pix_ready, 1);
        chk("rst_mm_tvalid", bus.mm_tvalid, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        chk("rst_mm_a", bus.mm_a, 0);
        chk("rst_out_data", bus.out_data, 0);

        for (int i = 0; i < 16; i++) begin
            bus.mat_we    = 1'b1;
            bus.mat_addr  = 4'(i);
            bus.mat_wdata = m_init[i];
            exp_m[i]      = m_init[i];
            tick();
        end
        bus.mat_we = 1'b0;

        // Reference pixel
        accept(PIX1);
        feed_pairs(PIX1);
        deliver(RES);

        // Backpressure with a second pixel waiting
        accept(PIX1);
        feed_pairs(PIX1);
        tick();
        pulse_done(RES);
        bus.pix_data  = PIX2;
        bus.pix_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("bp_out_valid_c%0d", c), bus.out_valid, 1);
            chk($sformatf("bp_out_data_c%0d", c), bus.out_data, RES);
            chk($sformatf("bp_pix_ready_c%0d", c), bus.pix_ready, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_hs_out_valid", bus.out_valid, 0);
        chk("bp_hs_pix_ready", bus.pix_ready, 1);
        chk("bp_not_yet_accepted", bus.mm_tvalid, 0);
        tick();
        bus.pix_valid = 1'b0;

        // Second pixel never gets done: timeout
        feed_pairs(PIX2);
        ov_seen = 0;
        for (int c = 0; c < TMO - 2; c++) begin
            tick();
            if (bus.out_valid) ov_seen++;
        end
        chk("tmo_not_yet", bus.timeout_err, 0);
        chk("tmo_busy_before", bus.busy, 1);
        tick();
        if (bus.out_valid) ov_seen++;
        chk("tmo_set", bus.timeout_err, 1);
        chk("tmo_idle", bus.pix_ready, 1);
        chk("tmo_busy_after", bus.busy, 0);
        chk("tmo_no_out_valid", ov_seen, 0);

        // Same-cycle write at acceptance, then writes during FEED are locked out
        bus.mat_we    = 1'b1;
        bus.mat_addr  = 4'd0;
        bus.mat_wdata = 32'h3F800000;
        exp_m[0]      = 32'h3F800000;
        accept(PIX1);
        bus.mat_wdata = 32'h00000000;
        feed_pairs(PIX1);
        bus.mat_we    = 1'b0;
        deliver(RES);
        chk("tmo_sticky", bus.timeout_err, 1);
        accept(PIX1);
        feed_pairs(PIX1);
        deliver(RES);

        // Reset during FEED at k=7
        accept(PIX2);
        for (int c = 0; c < 7; c++) tick();
        chk("pre_rst_tvalid", bus.mm_tvalid, 1);
        chk("pre_rst_mm_a_k7", bus.mm_a, exp_m[7]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_tvalid", bus.mm_tvalid, 0);
        chk("mid_rst_pix_ready", bus.pix_ready, 1);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_timeout_err", bus.timeout_err, 0);
        chk("mid_rst_mm_a", bus.mm_a, 0);
        bus.mm_done    = 1'b1;
        bus.mm_result0 = 32'hDEADBEEF;
        tick();
        bus.mm_done    = 1'b0;
        bus.mm_result0 = '0;
        chk("idle_done_ignored", bus.out_valid, 0);
        chk("idle_done_busy", bus.busy, 0);
        for (int i = 0; i < 16; i++) exp_m[i] = '0;
        accept(PIX2);
        feed_pairs(PIX2);
        deliver(RES);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
